// File: rtl/instruction_sequencer_if.sv
// Host-program, instruction-memory and CPU-fetch signals of the instruction sequencer.
// The sequencer connects through the slave modport; the driving environment uses master.
interface instruction_sequencer_if #(
    parameter int IW    = 12,
    parameter int DEPTH = 8
);
    localparam int PW = $clog2(DEPTH);

    logic          prog_valid;
    logic [IW-1:0] prog_data;
    logic          prog_ready;
    logic          run;
    logic          abort;
    logic          mem_load;
    logic [IW-1:0] mem_data;
    logic [PW-1:0] mem_index;
    logic [IW-1:0] mem_out;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          branch_en;
    logic [PW-1:0] branch_target;
    logic [1:0]    state;

    modport slave (
        input  prog_valid, prog_data, run, abort, mem_out,
               instr_ready, branch_en, branch_target,
        output prog_ready, mem_load, mem_data, mem_index,
               instr, instr_valid, state
    );

    modport master (
        output prog_valid, prog_data, run, abort, mem_out,
               instr_ready, branch_en, branch_target,
        input  prog_ready, mem_load, mem_data, mem_index,
               instr, instr_valid, state
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Loads a program into an external shift-in instruction memory, then fetches it to a CPU.
// Define SEQ_LOOP_EN to wrap from the last index to 0 instead of stopping in DONE.
module instruction_sequencer #(
    parameter int IW    = 12,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [PW-1:0] PC_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic          mem_load_q, mem_load_d;
    logic [IW-1:0] mem_data_q, mem_data_d;
    logic          armed_q, armed_d;

    logic prog_ready;
    logic accept;
    logic consume;
    logic in_run;

    // armed_q stays low for the first cycle after reset while the memory clears itself.
    assign in_run     = (state_q == S_RUN);
    assign prog_ready = armed_q && !state_q[1] && (load_cnt_q < CNT_FULL)
                        && !bus.run && !bus.abort;
    assign accept     = bus.prog_valid && prog_ready;
    assign consume    = in_run && bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_cnt_d = load_cnt_q;
        mem_data_d = mem_data_q;
        mem_load_d = accept;
        armed_d    = 1'b1;

        if (accept) begin
            mem_data_d = bus.prog_data;
            if (load_cnt_q < CNT_FULL) begin
                load_cnt_d = load_cnt_q + CW'(1);
            end
        end

        if (bus.abort) begin
            state_d    = S_IDLE;
            pc_d       = '0;
            load_cnt_d = '0;
            mem_load_d = 1'b0;
        end else if (bus.run) begin
            state_d = S_RUN;
            pc_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_LOAD;
                    end
                end
                S_RUN: begin
                    if (consume) begin
                        if (bus.branch_en) begin
                            pc_d = bus.branch_target;
                        end else if (pc_q != PC_LAST) begin
                            pc_d = pc_q + PW'(1);
                        end else begin
`ifdef SEQ_LOOP_EN
                            pc_d = '0;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            load_cnt_q <= '0;
            mem_load_q <= 1'b0;
            mem_data_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_cnt_q <= load_cnt_d;
            mem_load_q <= mem_load_d;
            mem_data_q <= mem_data_d;
            armed_q    <= armed_d;
        end
    end

    // An abort arriving while a shift-in strobe is out cancels that strobe too.
    assign bus.prog_ready  = prog_ready;
    assign bus.mem_load    = mem_load_q && !bus.abort;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_index   = in_run ? pc_q : '0;
    assign bus.instr       = in_run ? bus.mem_out : '0;
    assign bus.instr_valid = in_run;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: shift-in memory environment plus a program-level reference model.
module tb_instruction_sequencer;
    localparam int IW    = 12;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_sequencer_if #(.IW(IW), .DEPTH(DEPTH)) sif ();
    instruction_sequencer #(.IW(IW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(sif));

    // Instruction memory: cleared by reset, newest word enters at the top index.
    logic [IW-1:0] tb_mem [DEPTH];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= '0;
        end else if (sif.mem_load) begin
            for (int i = 0; i < DEPTH - 1; i++) tb_mem[i] <= tb_mem[i+1];
            tb_mem[DEPTH-1] <= sif.mem_data;
        end
    end
    always_comb sif.mem_out = tb_mem[sif.mem_index];

    int checks   = 0;
    int failures = 0;
    int loads_seen;
    int first_acc;

    // Reference model: mode 0=IDLE 1=LOAD 2=RUN 3=DONE, plus history of words written into memory.
    int            m_state, m_pc, m_cnt;
    bit            m_pend, m_init;
    logic [IW-1:0] m_data;
    logic [IW-1:0] hist [$];

    function automatic logic [IW-1:0] exp_word(input int idx);
        int k;
        k = hist.size() - DEPTH + idx;
        return (k >= 0) ? hist[k] : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_pc = 0; m_cnt = 0;
        m_pend = 1'b0; m_init = 1'b0; m_data = '0;
        hist.delete();
    endtask

    // One clock cycle: drive, check all outputs against the model, clock, advance the model.
    task automatic cyc(input bit pv, input logic [IW-1:0] pd, input bit rn, input bit ab,
                       input bit rd, input bit br, input int tg, input string tag);
        bit ready, acc;
        sif.prog_valid    = pv;
        sif.prog_data     = pd;
        sif.run           = rn;
        sif.abort         = ab;
        sif.instr_ready   = rd;
        sif.branch_en     = br;
        sif.branch_target = tg[PW-1:0];
        #1;
        ready = m_init && (m_state <= 1) && (m_cnt < DEPTH) && !rn && !ab;
        chk({tag, ".state"}, sif.state, m_state);
        chk({tag, ".prog_ready"}, sif.prog_ready, ready);
        chk({tag, ".mem_load"}, sif.mem_load, m_pend && !ab);
        chk({tag, ".mem_data"}, sif.mem_data, m_data);
        chk({tag, ".instr_valid"}, sif.instr_valid, m_state == 2);
        chk({tag, ".mem_index"}, sif.mem_index, (m_state == 2) ? m_pc : 0);
        if (m_state == 2) chk({tag, ".instr"}, sif.instr, exp_word(m_pc));
        if (sif.mem_load) loads_seen++;
        @(posedge clk);
        if (m_pend && !ab) hist.push_back(m_data);
        acc = pv && ready;
        if (acc) m_data = pd;
        m_pend = acc;
        if (ab) begin
            m_state = 0; m_pc = 0; m_cnt = 0;
        end else if (rn) begin
            m_state = 2; m_pc = 0;
        end else if (m_state == 0 && acc) begin
            m_state = 1;
        end else if (m_state == 2 && rd) begin
            if (br) m_pc = tg % DEPTH;
            else if (m_pc < DEPTH - 1) m_pc = m_pc + 1;
            else begin
`ifdef SEQ_LOOP_EN
                m_pc = 0;
`else
                m_state = 3;
`endif
            end
        end
        if (acc) m_cnt = m_cnt + 1;
        m_init = 1'b1;
        #1;
    endtask

    task automatic async_reset(input string tag);
        sif.prog_valid = 0; sif.run = 0; sif.abort = 0;
        sif.instr_ready = 0; sif.branch_en = 0;
        #2;
        reset = 1'b0;
        #1;
        chk({tag, ".state"}, sif.state, 0);
        chk({tag, ".instr_valid"}, sif.instr_valid, 0);
        chk({tag, ".mem_index"}, sif.mem_index, 0);
        chk({tag, ".mem_load"}, sif.mem_load, 0);
        chk({tag, ".prog_ready"}, sif.prog_ready, 0);
        model_clear();
        @(posedge clk);
        #1;
        chk({tag, ".mem_data"}, sif.mem_data, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        sif.prog_valid = 1'b1; sif.prog_data = 12'h5a5; sif.run = 0; sif.abort = 0;
        sif.instr_ready = 0; sif.branch_en = 0; sif.branch_target = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.state", sif.state, 0);
        chk("rst.prog_ready", sif.prog_ready, 0);
        chk("rst.mem_load", sif.mem_load, 0);
        chk("rst.mem_data", sif.mem_data, 0);
        chk("rst.instr_valid", sif.instr_valid, 0);
        chk("rst.mem_index", sif.mem_index, 0);
        reset = 1'b1;

        // prog_valid held high from reset release
        loads_seen = 0;
        first_acc  = -1;
        for (int c = 0; c < 14; c++) begin
            cyc(1, IW'($urandom), 0, 0, 0, 0, 0, "fill");
            if (sif.mem_load && first_acc < 0) first_acc = c + 1;
        end
        chk("fill.first_accept_edge", first_acc, 2);
        chk("fill.pulses", loads_seen, DEPTH);
        chk("fill.ready_when_full", sif.prog_ready, 0);
        chk("fill.state", sif.state, 1);
        for (int i = 0; i < DEPTH; i++) chk("fill.mem", tb_mem[i], exp_word(i));

        // reload 0x101..0x108 over old contents with random bubbles, then run to the end
        cyc(0, 0, 0, 1, 0, 0, 0, "abort1");
        for (int k = 0; k < DEPTH;) begin
            bit pv;
            pv = ($urandom_range(0, 3) != 0);
            cyc(pv, IW'(12'h101 + k), 0, 0, 0, 0, 0, "load");
            if (pv) k++;
        end
        cyc(0, 0, 1, 0, 0, 0, 0, "run1");
        for (int i = 0; i < DEPTH; i++) begin
            chk("seq.instr", sif.instr, 12'h101 + i);
            cyc(0, 0, 0, 0, 1, 0, 0, "seq");
        end
`ifdef SEQ_LOOP_EN
        chk("seq.wrap_instr", sif.instr, 12'h101);
        chk("seq.wrap_state", sif.state, 2);
`else
        chk("seq.done_state", sif.state, 3);
        chk("seq.done_valid", sif.instr_valid, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, "done_hold");
        chk("seq.done_hold", sif.state, 3);
`endif

        // branches, including from the last index
        cyc(0, 0, 1, 0, 0, 0, 0, "run2");
        cyc(0, 0, 0, 0, 1, 0, 0, "br");
        cyc(0, 0, 0, 0, 1, 0, 0, "br");
        cyc(0, 0, 0, 0, 1, 1, 6, "br_at2");
        chk("br.to6", sif.instr, 12'h107);
        cyc(0, 0, 0, 0, 1, 0, 0, "br");
        chk("br.at7", sif.instr, 12'h108);
        cyc(0, 0, 0, 0, 1, 1, 3, "br_at7");
        chk("br.to3", sif.instr, 12'h104);
        chk("br.state", sif.state, 2);

        // CPU stall at index 4
        cyc(0, 0, 0, 0, 1, 0, 0, "to4");
        for (int i = 0; i < 5; i++) begin
            cyc($urandom_range(0, 1), IW'($urandom), 0, 0, 0, 1, $urandom_range(0, 7), "stall");
            chk("stall.index", sif.mem_index, 4);
            chk("stall.instr", sif.instr, 12'h105);
            chk("stall.valid", sif.instr_valid, 1);
        end

        // run wins over a simultaneous consume with branch
        cyc(0, 0, 1, 0, 1, 1, 5, "run_vs_consume");
        chk("restart.index", sif.mem_index, 0);

        for (int i = 0; i < 60; i++)
            cyc($urandom_range(0, 1), IW'($urandom), ($urandom_range(0, 15) == 0), 0,
                $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 7), "rand");

        // abort while word 4 is being written and word 5 is offered
        cyc(0, 0, 0, 1, 0, 0, 0, "abort2");
        for (int i = 0; i < 4; i++) cyc(1, IW'($urandom), 0, 0, 0, 0, 0, "pre_abort");
        cyc(1, IW'($urandom), 0, 1, 0, 0, 0, "abort_word5");
        chk("abort.state", sif.state, 0);
        chk("abort.mem_load", sif.mem_load, 0);
        loads_seen = 0;
        for (int i = 0; i < 12; i++) cyc(1, IW'($urandom), 0, 0, 0, 0, 0, "refill");
        chk("abort.refill_pulses", loads_seen, DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("abort.mem", tb_mem[i], exp_word(i));

        // asynchronous reset mid-run and mid-load
        cyc(0, 0, 1, 0, 0, 0, 0, "run3");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, $urandom_range(0, 1), 0, 0, "run3");
        async_reset("rst_run");
        cyc(0, 0, 0, 0, 0, 0, 0, "post_rst");
        cyc(1, IW'($urandom), 0, 0, 0, 0, 0, "load_rst");
        async_reset("rst_load");
        cyc(0, 0, 0, 0, 0, 0, 0, "post_rst2");
        chk("rst_load.no_pulse", sif.mem_load, 0);

        // run with nothing loaded executes the cleared memory
        cyc(0, 0, 1, 0, 0, 0, 0, "run_empty");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0, "run_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter: IW, 12, instruction word width.
REQ-002 SHALL have parameter: DEPTH, 8, instruction memory entries; PC width is log2(DEPTH) = 3.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 prog_valid  in  1  host program word valid.
REQ-006 prog_data  in  IW  host program word.
REQ-007 prog_ready  out  1  sequencer can accept a program word.
REQ-008 run  in  1  start/restart execution from index 0.
REQ-009 abort  in  1  return to IDLE and discard load count.
REQ-010 mem_load  out  1  shift-in strobe to instruction memory.
REQ-011 mem_data  out  IW  word shifted into memory.
REQ-012 mem_index  out  3  memory read index.
REQ-013 mem_out  in  IW  memory read data, combinational on mem_index.
REQ-014 instr  out  IW  fetched instruction to CPU.
REQ-015 instr_valid  out  1  instr valid.
REQ-016 instr_ready  in  1  CPU consumes instr.
REQ-017 branch_en  in  1  redirect next fetch, sampled with the consume handshake.
REQ-018 branch_target  in  3  redirect index.
REQ-019 state  out  2  IDLE=00, LOAD=01, RUN=10, DONE=11.

Function
REQ-020 SHALL hold prog_ready=0 for the first clk cycle after reset deasserts, covering the memory's clear cycle.
REQ-021 prog_ready SHALL be 1 only in IDLE/LOAD, when load_cnt<DEPTH, run=0 and abort=0.
REQ-022 On prog_valid&&prog_ready, SHALL register prog_data into mem_data and pulse mem_load=1 for exactly the next cycle, giving 1-cycle latency.
REQ-023 Each accepted word SHALL increment load_cnt, 4-bit and saturating at DEPTH.
REQ-024 The first accepted word SHALL move IDLE->LOAD.
REQ-025 At load_cnt=DEPTH, SHALL deassert prog_ready; further prog_valid is ignored.
REQ-026 The first of DEPTH words loaded SHALL reside at index 0, the last at index 7.
REQ-027 run in IDLE/LOAD/DONE SHALL enter RUN with pc=0; a pending mem_load pulse SHALL still complete.
REQ-028 run in IDLE with load_cnt=0 SHALL be legal and SHALL execute the current memory contents.
REQ-029 In RUN, mem_index SHALL equal pc, instr SHALL equal mem_out, and instr_valid SHALL be 1; otherwise mem_index=0 and instr_valid=0.
REQ-030 instr and instr_valid SHALL hold stable until instr_ready=1; mem_load SHALL never assert in RUN.
REQ-031 On instr_valid&&instr_ready with branch_en=1, SHALL set pc<=branch_target, including at pc=7.
REQ-032 On instr_valid&&instr_ready with branch_en=0 and pc<7, SHALL set pc<=pc+1.
REQ-033 On a consume at pc=7 with branch_en=0, behaviour SHALL follow REQ-039/040.
REQ-034 run asserted in RUN SHALL restart at pc=0 and SHALL take priority over a simultaneous consume.
REQ-035 abort in any state SHALL go to IDLE, clearing pc and load_cnt and cancelling a pending mem_load; abort SHALL win over run and over prog handshake.
REQ-036 Memory contents SHALL NOT be cleared by abort; a reload shifts new words in over old ones.

Reset
REQ-037 While reset=0: state=IDLE, pc=0, load_cnt=0, mem_load=0, mem_data=0, prog_ready=0, instr_valid=0, mem_index=0.
REQ-038 Reset mid-load or mid-run SHALL drop the operation with no further mem_load.

Configuration
REQ-039 With SEQ_LOOP_EN defined, a pc=7 non-branch consume SHALL wrap pc to 0 and stay in RUN.
REQ-040 With SEQ_LOOP_EN undefined, the same event SHALL enter DONE with instr_valid=0 until run or abort.

Verification
REQ-041 Load 0x101..0x108, then run, instr_ready=1 -> instr sequence 0x101..0x108; then DONE (no SEQ_LOOP_EN) or 0x101 again (SEQ_LOOP_EN).
REQ-042 prog_valid=1 from reset release -> first acceptance 2nd cycle after deassert; mem_load pulses exactly 8 times, then prog_ready=0.
REQ-043 RUN at pc=2, branch_en=1, target=6, consume -> next instr=mem[6]; branch at pc=7 to 3 -> instr=mem[3], still RUN.
REQ-044 instr_ready=0 for 5 cycles at pc=4 -> instr and instr_valid stable, pc=4 throughout.
REQ-045 abort during word 5 acceptance -> no mem_load next cycle, state=IDLE, load_cnt=0; async reset mid-run -> instr_valid=0 immediately.
